led_shift_tx: RTL and testbench
===============================

# led_shift_tx

Serializer that feeds the 16-bit LED shift-register chain. It accepts a 16-bit parallel word through a valid/ready handshake and shifts it out MSB-first. It generates the chain's shift clock, serial data and shift-enable (`s_l`), and pulses `done` when the word is in place. It sits between the game-state/display logic and the two cascaded 8-bit LED shift stages.

## Interface
- `CLK_DIV`, 4: system cycles per sclk half-period, ≥1.
- `WIDTH`, 16: bits per frame, ≥2.
- `REFRESH_CYCLES`, 1_000_000: idle cycles between automatic re-sends. Used only with the refresh macro.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in WIDTH: word to display.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block can accept a word. High only in IDLE.
- `sclk` out 1: shift clock to the chain. The chain samples on the rising edge.
- `sdat` out 1: serial data to the chain.
- `s_l` out 1: 1 = chain shifts, 0 = chain holds.
- `done` out 1: one-cycle pulse when a frame has completed.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - `in_ready`=1, `s_l`=0, `sclk`=0.
  - On `in_valid && in_ready`: load `in_data` into shift register `sr`, set `bit_cnt`=0 and `div_cnt`=0, go to LOW.
- **LOW**
  - `sclk`=0, `s_l`=1, `sdat`=`sr[WIDTH-1]`.
  - After CLK_DIV cycles, go to HIGH.
- **HIGH**
  - `sclk`=1, `s_l`=1, `sdat` unchanged.
  - After CLK_DIV cycles:
    - If `bit_cnt`==WIDTH-1, go to DONE.
    - Otherwise shift `sr` left by 1, increment `bit_cnt`, go to LOW.
- **DONE**
  - `done`=1 for exactly one cycle, `s_l`=0, `sclk`=0, then go to IDLE.
- `in_data` is sampled only on the accept cycle. Later changes to `in_data` or `in_valid` during a frame are ignored.
- A shadow register `last_word` captures every accepted word.
- Bit order: `in_data[WIDTH-1]` is shifted first. After the frame, the chain holds `in_data` with bit WIDTH-1 at the far end.
- Counter widths:
  - `div_cnt`: $clog2(CLK_DIV+1) bits.
  - `bit_cnt`: $clog2(WIDTH) bits.
  - Neither counter wraps outside its state's terminal count.

## Timing
- Reset values (registered outputs): `sclk`=0, `sdat`=0, `s_l`=0, `done`=0, `in_ready`=1 from the first cycle after reset. State = IDLE, `sr`=0, `last_word`=0.
- All outputs are registered. There is no combinational path from `in_valid` to any output.
- Taking the accept edge as cycle 0:
  - Cycles 1..CLK_DIV are LOW for bit WIDTH-1.
  - The first rising edge of `sclk` is at cycle CLK_DIV+1.
  - The frame occupies 2·CLK_DIV·WIDTH cycles.
  - `done` is high in cycle 2·CLK_DIV·WIDTH+1.
  - `in_ready` returns high in the following cycle.
- With defaults: 128 shift cycles, `done` at cycle 129, next accept possible at cycle 130.
- `sdat` changes only on entry to LOW. It is stable for all of HIGH, so setup and hold to the chain equal CLK_DIV cycles.
- `in_valid` held high back-to-back gives one accepted word per frame. There is no queuing.
- Reset mid-frame: the frame is abandoned. All outputs take their reset values on the next edge. No `done` is produced. The chain contents are undefined.
- `rst` and `in_valid` in the same cycle: reset wins and nothing is accepted.

## Configuration
- Macro: `LED_SHIFT_TX_AUTO_REFRESH_EN`.
- **Defined**
  - An idle counter runs while the block is in IDLE.
  - When the counter reaches REFRESH_CYCLES with `in_valid`=0, the block re-sends `last_word` exactly as a normal frame and pulses `done` at the end.
  - If `in_valid` is high in that same cycle, the new word takes priority.
  - Every accept and every reset clears the counter.
- **Undefined**
  - There is no counter and the block is purely on-demand.
  - `REFRESH_CYCLES` is ignored.

## Structure
- Shared package `led_pkg`:
  - State enum `led_tx_state_t` (IDLE/LOW/HIGH/DONE).
  - `LED_WIDTH`=16.
  - Default `LED_CLK_DIV`.
- One natural sub-module: `led_clk_div`. It is a CLK_DIV terminal-count counter with clear. It produces the phase-end strike used by LOW and HIGH, and it is reused for the refresh counter.

## Test plan
- Reset, then `in_data`=16'hA5C3, `in_valid` for 1 cycle → `sdat` sampled at the 16 `sclk` rising edges reads 1010_0101_1100_0011. `done` is asserted at cycle 129. `s_l`=1 only during cycles 1..128.
- CLK_DIV=1, `in_data`=16'hFFFF → `sclk` toggles every cycle, 16 rising edges, `done` at cycle 33.
- `in_valid` held high with 16'h0001 then 16'h8000 → the second word is accepted only on the cycle after `done`. `in_data` changes mid-frame do not alter `sdat`.
- `rst` asserted at cycle 50 of a frame → all outputs are 0 and `in_ready`=1 on the next cycle. No `done` appears. A new frame then runs normally.
- With the macro defined and REFRESH_CYCLES=20: send 16'h1234, then idle → an identical frame starts after 20 idle cycles. An `in_valid` landing on the refresh cycle sends the new word instead.
- `in_valid` asserted together with `rst` → nothing is accepted. `s_l` stays 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED chain serializer.
// The auto-refresh option is selected with LED_SHIFT_TX_AUTO_REFRESH_EN.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } led_tx_state_t;

  localparam int LED_WIDTH   = 16;
  localparam int LED_CLK_DIV = 4;

endpackage

// File: rtl/led_shift_tx_if.sv
// Parallel-word handshake between the display logic and the LED serializer.
interface led_shift_tx_if
  import led_pkg::*;
#(
  parameter int WIDTH = LED_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             done;

  modport master (output in_data, output in_valid, input in_ready, input done);
  modport slave  (input in_data, input in_valid, output in_ready, output done);

endinterface

// File: rtl/led_clk_div.sv
// Terminal-count counter with clear; tick marks the last enabled cycle of a LIMIT-cycle period.
module led_clk_div
  import led_pkg::*;
#(
  parameter int LIMIT = LED_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/led_shift_tx.sv
// MSB-first serializer for the cascaded LED shift stages, all outputs registered.
// Optional periodic re-send of the last word is enabled by LED_SHIFT_TX_AUTO_REFRESH_EN.
//
// state | meaning
// IDLE  | ready for a word, chain holding
// LOW   | sclk low, sdat presents the current bit
// HIGH  | sclk high, chain samples on entry
// DONE  | one-cycle done pulse, back to IDLE
module led_shift_tx
  import led_pkg::*;
#(
  parameter int CLK_DIV        = LED_CLK_DIV,
  parameter int WIDTH          = LED_WIDTH,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           rst,
  led_shift_tx_if.slave  bus,
  output logic           sclk,
  output logic           sdat,
  output logic           s_l
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOW  = LOW;
  localparam logic [1:0] S_HIGH = HIGH;
  localparam logic [1:0] S_DONE = DONE;
  localparam int         BW     = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] last_word;
  logic [BW-1:0]    bit_cnt;
  logic             done_q;
  logic             ready_q;
  logic             accept;
  logic             start;
  logic [WIDTH-1:0] start_word;
  logic             phase_end;

  assign accept     = (state == S_IDLE) && bus.in_valid;
  assign start_word = accept ? bus.in_data : last_word;

  led_clk_div #(.LIMIT(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_IDLE),
    .en   ((state == S_LOW) || (state == S_HIGH)),
    .tick (phase_end)
  );

`ifdef LED_SHIFT_TX_AUTO_REFRESH_EN
  logic refresh_tick;

  // Counts idle cycles only; a fresh word in the refresh cycle wins via start_word.
  led_clk_div #(.LIMIT(REFRESH_CYCLES)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == S_IDLE),
    .tick (refresh_tick)
  );

  assign start = accept || refresh_tick;
`else
  logic unused_refresh;

  assign unused_refresh = ^32'(REFRESH_CYCLES);
  assign start          = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      last_word <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      sdat      <= 1'b0;
      s_l       <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sr      <= start_word;
            bit_cnt <= '0;
            sdat    <= start_word[WIDTH-1];
            s_l     <= 1'b1;
            ready_q <= 1'b0;
            state   <= S_LOW;
            if (accept) begin
              last_word <= bus.in_data;
            end
          end
        end
        S_LOW: begin
          if (phase_end) begin
            sclk  <= 1'b1;
            state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            sclk <= 1'b0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              s_l    <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              // sdat only moves here, on entry to LOW, so it is stable across HIGH
              sr      <= {sr[WIDTH-2:0], 1'b0};
              sdat    <= sr[WIDTH-2];
              bit_cnt <= bit_cnt + BW'(1);
              state   <= S_LOW;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_led_shift_tx.sv
// Self-checking bench for led_shift_tx: frame timing and bit order against a word-level model.
module tb_led_shift_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   sel = 1'b0;

  logic sclk0, sdat0, sl0, sclk1, sdat1, sl1;
  logic m_sclk, m_sdat, m_sl, m_done, m_ready;

  led_shift_tx_if #(.WIDTH(16)) bus  ();
  led_shift_tx_if #(.WIDTH(16)) bus1 ();

  led_shift_tx #(.CLK_DIV(4), .WIDTH(16), .REFRESH_CYCLES(20)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sclk (sclk0),
    .sdat (sdat0),
    .s_l  (sl0)
  );

  led_shift_tx #(.CLK_DIV(1), .WIDTH(16), .REFRESH_CYCLES(1_000_000)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus1),
    .sclk (sclk1),
    .sdat (sdat1),
    .s_l  (sl1)
  );

  always #5 clk = ~clk;

  assign m_sclk  = sel ? sclk1 : sclk0;
  assign m_sdat  = sel ? sdat1 : sdat0;
  assign m_sl    = sel ? sl1   : sl0;
  assign m_done  = sel ? bus1.done     : bus.done;
  assign m_ready = sel ? bus1.in_ready : bus.in_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) bus1.in_valid = v;
    else     bus.in_valid  = v;
  endtask

  task automatic set_data(input logic [15:0] d);
    if (sel) bus1.in_data = d;
    else     bus.in_data  = d;
  endtask

  // Caller has set in_valid/in_data so the next posedge is the accept edge (cycle 0).
  // Model: 2*div*16 shift cycles, done in the cycle after, ready the cycle after that,
  // 16 sclk rises carrying the word MSB first, first rise at cycle div+1.
  task automatic capture(input int div, input logic [15:0] exp_word, input bit hold,
                         input logic [15:0] after_word, input bit scramble);
    int rises = 0, first_rise = 0, done_cyc = 0, done_cnt = 0;
    int sl_cnt = 0, sl_last = 0, rdy_hi = 0;
    int shift_cycles = 2 * div * 16;
    logic prev = 1'b0;
    logic [15:0] got = '0;
    for (int k = 1; k <= shift_cycles + 2; k++) begin
      @(negedge clk);
      if (m_sclk && !prev) begin
        rises++;
        if (rises == 1) first_rise = k;
        got = {got[14:0], m_sdat};
      end
      prev = m_sclk;
      if (m_sl) begin sl_cnt++; sl_last = k; end
      if (m_done) begin done_cnt++; done_cyc = k; end
      if (k <= shift_cycles + 1 && m_ready) rdy_hi++;
      if (k == shift_cycles + 2) chk("ready_after_done", {31'b0, m_ready}, 32'd1);
      if (k == 1) begin
        set_data(after_word);
        if (!hold) set_valid(1'b0);
      end else if (scramble) begin
        set_data(16'($urandom));
      end
    end
    chk("frame_word", {16'b0, got}, {16'b0, exp_word});
    chk("sclk_rises", rises, 16);
    chk("first_rise_cycle", first_rise, div + 1);
    chk("done_cycle", done_cyc, shift_cycles + 1);
    chk("done_count", done_cnt, 1);
    chk("s_l_cycles", sl_cnt, shift_cycles);
    chk("s_l_last", sl_last, shift_cycles);
    chk("ready_low_in_frame", rdy_hi, 0);
  endtask

  initial begin
    logic [15:0] w;
    int n_done, n_sl, n_rdy;
    bit seen;
    bus.in_data = '0;  bus.in_valid = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'b0, sclk0, sdat0, sl0, bus.done, bus.in_ready}, 32'b00001);
    chk("reset_outputs_div1", {27'b0, sclk1, sdat1, sl1, bus1.done, bus1.in_ready}, 32'b00001);
    rst = 1'b0;

    // CLK_DIV=1, all ones
    sel = 1'b1;
    set_data(16'hFFFF); set_valid(1'b1);
    capture(1, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
    sel = 1'b0;

`ifdef LED_SHIFT_TX_AUTO_REFRESH_EN
    // dut has been idle long enough to start a refresh; let it finish
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("refresh_settle", {31'b0, seen}, 32'd1);
    @(negedge clk);
`endif

    // directed frame, in_data scrambled mid-frame
    bus.in_data = 16'hA5C3; bus.in_valid = 1'b1;
    capture(4, 16'hA5C3, 1'b0, 16'h0000, 1'b1);

`ifdef LED_SHIFT_TX_AUTO_REFRESH_EN
    bus.in_data = 16'h1234; bus.in_valid = 1'b1;
    capture(4, 16'h1234, 1'b0, 16'h0000, 1'b0);
    n_rdy = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (bus.in_ready && !sl0) n_rdy++;
    end
    chk("refresh_idle_wait", n_rdy, 19);
    capture(4, 16'h1234, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i == 19) begin bus.in_data = 16'h5A5A; bus.in_valid = 1'b1; end
    end
    capture(4, 16'h5A5A, 1'b0, 16'h0000, 1'b0);
`endif

    // back-to-back with in_valid held high
    bus.in_data = 16'h0001; bus.in_valid = 1'b1;
    capture(4, 16'h0001, 1'b1, 16'h8000, 1'b0);
    capture(4, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // reset in cycle 50 of a frame
    bus.in_data = 16'($urandom); bus.in_valid = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midframe_reset_outputs", {27'b0, sclk0, sdat0, sl0, bus.done, bus.in_ready}, 32'b00001);
    rst = 1'b0;
    n_done = 0; n_sl = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (sl0) n_sl++;
    end
    chk("no_done_after_reset", n_done, 0);
    chk("no_shift_after_reset", n_sl, 0);
    w = 16'($urandom);
    bus.in_data = w; bus.in_valid = 1'b1;
    capture(4, w, 1'b0, 16'h0000, 1'b0);

    // in_valid together with rst
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'($urandom);
    @(negedge clk);
    chk("rst_valid_s_l", {31'b0, sl0}, 32'd0);
    chk("rst_valid_ready", {31'b0, bus.in_ready}, 32'd1);
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid_no_accept", {30'b0, sl0, bus.in_ready}, 32'b01);

    // random words
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      bus.in_data = w; bus.in_valid = 1'b1;
      capture(4, w, 1'b0, 16'h0000, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
